// File: rtl/operand_stack_mp.sv
// operand_stack_mp: operand stack for the wasm core. Each operation pops
// 0..MAX_POP entries and optionally pushes one entry in the same cycle. The
// top three entries are exposed for operand fetch. Overflow, underflow and a
// bad pop count latch a sticky trap code that holds until reset.
module operand_stack_mp #(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 16,
   parameter int MAX_POP = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         op_valid,
   input  logic [1:0]                   op_pop,
   input  logic                         op_push,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             top0,
   output logic [WIDTH-1:0]             top1,
   output logic [WIDTH-1:0]             top2,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output logic [3:0]                   trap
);

   localparam int CW = $clog2(DEPTH + 1);   // count width
   localparam int XW = CW + 1;              // widened so pop/push arithmetic cannot wrap
   localparam int AW = $clog2(DEPTH);       // storage address width

   localparam logic [3:0] TRAP_NONE  = 4'd0;
   localparam logic [3:0] TRAP_UNDER = 4'd1;
   localparam logic [3:0] TRAP_OVER  = 4'd2;
   localparam logic [3:0] TRAP_BADPOP = 4'd3;

   // Error classification in priority order: bad pop count, underflow, overflow.
   function automatic logic [3:0] f_classify(input logic [XW-1:0] pop_x,
                                             input logic [XW-1:0] count_x,
                                             input logic [XW-1:0] new_x);
      if (pop_x > XW'(MAX_POP)) begin
         return TRAP_BADPOP;
      end else if (pop_x > count_x) begin
         return TRAP_UNDER;
      end else if (new_x > XW'(DEPTH)) begin
         return TRAP_OVER;
      end else begin
         return TRAP_NONE;
      end
   endfunction

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [3:0]       r_trap;

   logic [XW-1:0]    w_count_x;
   logic [XW-1:0]    w_pop_x;
   logic [XW-1:0]    w_new_x;
   logic [3:0]       w_err;
   logic             w_commit;
   logic             w_ok;
   logic             w_we;
   logic [AW-1:0]    w_wr_addr;
   logic [AW-1:0]    w_i0;
   logic [AW-1:0]    w_i1;
   logic [AW-1:0]    w_i2;

   assign w_count_x = {1'b0, r_count};
   assign w_pop_x   = {{(XW-2){1'b0}}, op_pop};
   assign w_new_x   = w_count_x - w_pop_x + {{(XW-1){1'b0}}, op_push};
   assign w_err     = f_classify(w_pop_x, w_count_x, w_new_x);

   // An operation is only considered while no trap is latched.
   assign w_commit  = op_valid & (r_trap == TRAP_NONE);
   assign w_ok      = w_commit & (w_err == TRAP_NONE);
   assign w_we      = w_ok & op_push;

   // The pushed value lands directly above the entries that survive the pop.
   assign w_wr_addr = AW'(w_count_x - w_pop_x);

   // Count and sticky trap; an erroring operation changes nothing but the trap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_trap  <= TRAP_NONE;
      end else if (w_commit) begin
         if (w_err != TRAP_NONE) begin
            r_trap <= w_err;
         end else begin
            r_count <= CW'(w_new_x);
         end
      end
   end

   // Stack storage; contents are not cleared by reset, count alone defines validity.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_wr_addr] <= push_data;
      end
   end

   // Top-of-stack views come only from registered state.
   assign w_i0 = AW'(w_count_x - XW'(1));
   assign w_i1 = AW'(w_count_x - XW'(2));
   assign w_i2 = AW'(w_count_x - XW'(3));

   assign top0  = (w_count_x >= XW'(1)) ? r_mem[w_i0] : '0;
   assign top1  = (w_count_x >= XW'(2)) ? r_mem[w_i1] : '0;
   assign top2  = (w_count_x >= XW'(3)) ? r_mem[w_i2] : '0;
   assign count = r_count;
   assign empty = (r_count == CW'(0));
   assign full  = (r_count == CW'(DEPTH));
   assign trap  = r_trap;

endmodule

// File: tb/tb_operand_stack_mp.sv
// Bench for operand_stack_mp: directed operations with hand-computed results.
// Stimulus pushes the expected post-operation state into a queue; a monitor
// on the falling clock edge pops and compares against the selected instance.
module tb_operand_stack_mp;

   logic clk;
   logic reset;

   // Main instance: default parameters.
   logic        op_valid, op_push;
   logic [1:0]  op_pop;
   logic [63:0] push_data;
   logic [63:0] top0, top1, top2;
   logic [4:0]  count;
   logic        empty, full;
   logic [3:0]  trap;

   // Second instance: MAX_POP=2, small depth and width.
   logic        v2, push2;
   logic [1:0]  pop2;
   logic [7:0]  data2;
   logic [7:0]  t0_2, t1_2, t2_2;
   logic [2:0]  count2;
   logic        empty2, full2;
   logic [3:0]  trap2;

   operand_stack_mp dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_pop(op_pop),
      .op_push(op_push), .push_data(push_data), .top0(top0), .top1(top1),
      .top2(top2), .count(count), .empty(empty), .full(full), .trap(trap)
   );

   operand_stack_mp #(.WIDTH(8), .DEPTH(4), .MAX_POP(2)) dut2 (
      .clk(clk), .reset(reset), .op_valid(v2), .op_pop(pop2),
      .op_push(push2), .push_data(data2), .top0(t0_2), .top1(t1_2),
      .top2(t2_2), .count(count2), .empty(empty2), .full(full2), .trap(trap2)
   );

   typedef struct {
      int          sel;
      logic [4:0]  cnt;
      logic [63:0] t0;
      logic [63:0] t1;
      logic [63:0] t2;
      logic        emp;
      logic        ful;
      logic [3:0]  tr;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_s(input int sel, input string nm, input logic [4:0] c,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] d, input logic [3:0] tr,
                           input int depth);
      exp_t e;
      e.sel = sel; e.cnt = c; e.t0 = a; e.t1 = b; e.t2 = d; e.tr = tr;
      e.emp = (c == 5'd0);
      e.ful = (int'(c) == depth);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compare one queued expectation per falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         logic [4:0]  ac;
         logic [63:0] a0, a1, a2;
         logic        ae, af;
         logic [3:0]  at;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (e.sel == 0) begin
            ac = count; a0 = top0; a1 = top1; a2 = top2;
            ae = empty; af = full; at = trap;
         end else begin
            ac = {2'b00, count2}; a0 = {56'd0, t0_2}; a1 = {56'd0, t1_2};
            a2 = {56'd0, t2_2}; ae = empty2; af = full2; at = trap2;
         end
         n_tests++;
         if (ac !== e.cnt || a0 !== e.t0 || a1 !== e.t1 || a2 !== e.t2 ||
             ae !== e.emp || af !== e.ful || at !== e.tr) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d t0=%0d t1=%0d t2=%0d e=%0b f=%0b trap=%0d, want cnt=%0d t0=%0d t1=%0d t2=%0d e=%0b f=%0b trap=%0d",
                     nm, ac, a0, a1, a2, ae, af, at,
                     e.cnt, e.t0, e.t1, e.t2, e.emp, e.ful, e.tr);
         end
      end
   end

   task automatic op(input logic v, input logic [1:0] p, input logic pu,
                     input logic [63:0] d);
      @(negedge clk);
      op_valid = v; op_pop = p; op_push = pu; push_data = d;
      @(posedge clk);
      #1;
      op_valid = 1'b0; op_pop = 2'd0; op_push = 1'b0;
   endtask

   task automatic op_2(input logic [1:0] p, input logic pu, input logic [7:0] d);
      @(negedge clk);
      v2 = 1'b1; pop2 = p; push2 = pu; data2 = d;
      @(posedge clk);
      #1;
      v2 = 1'b0; pop2 = 2'd0; push2 = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset = 1'b0;
      #1;
      expect_s(0, "rst_pulse", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);
      @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      op_valid = 1'b0; op_pop = 2'd0; op_push = 1'b0; push_data = 64'd0;
      v2 = 1'b0; pop2 = 2'd0; push2 = 1'b0; data2 = 8'd0;
      #3;
      expect_s(0, "reset_state", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);
      expect_s(1, "reset_state2", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 4);
      #9;
      reset = 1'b1;

      // Pushes then select (3 -> 1)
      op(1'b1, 2'd0, 1'b1, 64'd10);
      expect_s(0, "push10", 5'd1, 64'd10, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd0, 1'b1, 64'd20);
      expect_s(0, "push20", 5'd2, 64'd20, 64'd10, 64'd0, 4'd0, 16);
      op(1'b1, 2'd0, 1'b1, 64'd1);
      expect_s(0, "push1", 5'd3, 64'd1, 64'd20, 64'd10, 4'd0, 16);
      op(1'b0, 2'd2, 1'b1, 64'd55);
      expect_s(0, "no_valid", 5'd3, 64'd1, 64'd20, 64'd10, 4'd0, 16);
      op(1'b1, 2'd3, 1'b1, 64'd20);
      expect_s(0, "select", 5'd1, 64'd20, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd1, 1'b0, 64'd0);
      expect_s(0, "drop", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd0, 1'b0, 64'd0);
      expect_s(0, "noop", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);

      // Underflow on empty, sticky, cleared by reset
      op(1'b1, 2'd1, 1'b0, 64'd0);
      expect_s(0, "underflow_empty", 5'd0, 64'd0, 64'd0, 64'd0, 4'd1, 16);
      op(1'b1, 2'd0, 1'b1, 64'd5);
      expect_s(0, "ignored_in_trap", 5'd0, 64'd0, 64'd0, 64'd0, 4'd1, 16);
      reset_pulse();
      op(1'b1, 2'd0, 1'b1, 64'd5);
      expect_s(0, "push5", 5'd1, 64'd5, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd1, 1'b0, 64'd0);
      expect_s(0, "pop5", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);

      // Fill to full with values 0..15
      for (int i = 0; i < 16; i++) begin
         op(1'b1, 2'd0, 1'b1, 64'(i));
         expect_s(0, "fill", 5'(i + 1), 64'(i),
                  (i >= 1) ? 64'(i - 1) : 64'd0,
                  (i >= 2) ? 64'(i - 2) : 64'd0, 4'd0, 16);
      end
      op(1'b1, 2'd1, 1'b1, 64'd99);
      expect_s(0, "replace_at_full", 5'd16, 64'd99, 64'd14, 64'd13, 4'd0, 16);
      op(1'b1, 2'd0, 1'b1, 64'd7);
      expect_s(0, "overflow", 5'd16, 64'd99, 64'd14, 64'd13, 4'd2, 16);
      op(1'b1, 2'd1, 1'b0, 64'd0);
      expect_s(0, "pop_ignored", 5'd16, 64'd99, 64'd14, 64'd13, 4'd2, 16);

      // Underflow with push: pop 3 of 2
      reset_pulse();
      op(1'b1, 2'd0, 1'b1, 64'd4);
      expect_s(0, "push4", 5'd1, 64'd4, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd0, 1'b1, 64'd8);
      expect_s(0, "push8", 5'd2, 64'd8, 64'd4, 64'd0, 4'd0, 16);
      op(1'b1, 2'd3, 1'b1, 64'd77);
      expect_s(0, "underflow_pop3", 5'd2, 64'd8, 64'd4, 64'd0, 4'd1, 16);

      // Async reset mid-cycle at count=4
      reset_pulse();
      for (int i = 1; i <= 4; i++) begin
         op(1'b1, 2'd0, 1'b1, 64'(i));
      end
      expect_s(0, "count4", 5'd4, 64'd4, 64'd3, 64'd2, 4'd0, 16);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      expect_s(0, "async_reset", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);
      @(negedge clk);
      #1;
      reset = 1'b1;
      op(1'b1, 2'd0, 1'b1, 64'd7);
      expect_s(0, "push7", 5'd1, 64'd7, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd0, 1'b1, 64'd9);
      expect_s(0, "push9", 5'd2, 64'd9, 64'd7, 64'd0, 4'd0, 16);
      op(1'b1, 2'd2, 1'b1, 64'd3);
      expect_s(0, "binop", 5'd1, 64'd3, 64'd0, 64'd0, 4'd0, 16);
      op(1'b1, 2'd1, 1'b0, 64'd0);
      expect_s(0, "pop_last", 5'd0, 64'd0, 64'd0, 64'd0, 4'd0, 16);

      // MAX_POP=2 instance: bad pop count outranks underflow
      op_2(2'd0, 1'b1, 8'd1);
      expect_s(1, "m2_push1", 5'd1, 64'd1, 64'd0, 64'd0, 4'd0, 4);
      op_2(2'd3, 1'b0, 8'd0);
      expect_s(1, "m2_badpop", 5'd1, 64'd1, 64'd0, 64'd0, 4'd3, 4);

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_stack_mp.md
Name: operand_stack_mp

Overview:
- Parametrised operand stack for the wasm CPU core. Generalises the fixed-width, single pop/push stack.
- Supports atomic multi-operand consume-and-produce: pop 0..MAX_POP entries and optionally push one entry in a single cycle. This serves select (3→1), binary ops (2→1), drop (1→0), const (0→1).
- Exposes the top three entries for operand fetch.
- Reports a sticky overflow/underflow trap to the core trap logic.

Parameters:
- WIDTH, 64, operand width in bits.
- DEPTH, 16, number of stack entries (≥4).
- MAX_POP, 3, largest pop count accepted per operation (1..3).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- op_valid  input  1  operation strobe; sampled on rising clk.
- op_pop  input  2  number of entries to pop (0..MAX_POP).
- op_push  input  1  push push_data after the pop.
- push_data  input  WIDTH  value pushed when op_push=1.
- top0  output  WIDTH  entry at top of stack; 0 if absent.
- top1  output  WIDTH  second entry; 0 if absent.
- top2  output  WIDTH  third entry; 0 if absent.
- count  output  $clog2(DEPTH+1)  current number of entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- trap  output  4  0=none, 1=stack underflow, 2=stack overflow, 3=bad pop count; sticky.

Behaviour:
- Reset (reset=0, asynchronous): count=0, trap=0, empty=1, full=0, top0..top2=0. Storage contents need not be cleared. Reset mid-operation discards the operation.
- Operation commits on a rising clk when op_valid=1 and trap==0.
  - new_count = count - op_pop + op_push.
  - When op_push=1, push_data is written at index count-op_pop (0-based from bottom).
- Latency: 1 cycle. count, empty, full and top0..top2 reflect the operation after the committing edge.
- Outputs are combinational from registered state only, with no path from op_* inputs. top0 = mem[count-1], top1 = mem[count-2], top2 = mem[count-3]; 0 where the index does not exist.
- Error checks, evaluated in priority order:
  1. op_pop > MAX_POP → trap=3.
  2. op_pop > count → trap=1.
  3. new_count > DEPTH → trap=2.
- On any error: no state change, trap latched.
- While trap≠0, all operations are ignored. State and trap hold until reset.
- Boundaries:
  - Pop-and-push at full is legal: count=DEPTH, pop=1, push=1 → count stays DEPTH, top replaced.
  - Push at full without pop → overflow.
  - pop=count with push=1 leaves exactly one entry.
  - op_valid=1 with op_pop=0 and op_push=0 is a legal no-op.
- count arithmetic is computed at width $clog2(DEPTH+1)+1 so comparisons cannot wrap.
- No combinational loops.
- Single clock domain. reset is not synchronised internally; the top level supplies a synchronously deasserted reset.

Test Plan:
- Reset then push 10, 20, 1 (op_pop=0, op_push=1) → count=3; top0=1, top1=20, top2=10; empty=0; trap=0.
- From that state, select: op_pop=3, op_push=1, push_data=20 → next cycle count=1, top0=20, top1=0, top2=0; trap=0.
- Fill to DEPTH=16 (values 0..15); then pop=1/push=1 with data=99 → count=16, top0=99, full=1. Then a push without pop → trap=2, count=16, top0=99. A subsequent pop=1 is ignored, count stays 16.
- Empty stack, op_pop=1 → trap=1, count=0, empty=1. Assert reset=0 for 1 cycle → trap=0. Push 5 → top0=5.
- Count=2, op_pop=3, op_push=1 → trap=1, count=2, top values unchanged. Separately, with MAX_POP=2, op_pop=3 → trap=3.
- Assert reset mid-stream between clock edges (count=4) → count, trap and top0 go to 0 immediately without waiting for clk. After reset is released, a push of 7 gives count=1 on the next edge.
